vip_gray_rank_filter: RTL and testbench
=======================================

// Module: vip_gray_rank_filter
// PURPOSE
//  Parametrised 3x3 rank-order filter for the gray VIP pipeline. Runtime-selectable modes: min (erode), median, max (dilate), bypass.
//  Sits after CMOS capture / gray conversion, ahead of frame difference; consumes and emits the standard vsync/href/clken pixel stream.
//  Generalises the fixed 8-bit 3x3 median filter with data width, selectable rank, border policy and frame-locked mode switching.
// PARAMETERS
//  DATA_W     8    pixel width in bits
//  IMG_HDISP  640  active pixels per line (line-buffer depth)
//  IMG_VDISP  480  active lines per frame (row-counter saturation value)
// PORTS
//  clk              in   1       pixel clock
//  rst_n            in   1       async active-low reset
//  per_frame_vsync  in   1       input vsync, high = frame active
//  per_frame_href   in   1       input href, high = line active
//  per_frame_clken  in   1       input pixel valid, one pixel per high cycle
//  per_img_Gray     in   DATA_W  input gray pixel
//  rank_sel         in   2       0=min 1=median 2=max 3=bypass
//  border_mode      in   1       0=border pixels output 0, 1=border pixels output raw input
//  post_frame_vsync out  1       per_frame_vsync delayed LAT clocks
//  post_frame_href  out  1       per_frame_href delayed LAT clocks
//  post_frame_clken out  1       per_frame_clken delayed LAT clocks
//  post_img_Gray    out  DATA_W  filtered pixel, valid when post_frame_clken=1
// BEHAVIOUR
//  - Reset: all outputs 0; counters 0; active mode = median; line-buffer RAM not reset (never read before it is written).
//  - Counters: col increments on clken, clears on href falling edge; row increments on href falling edge, clears while vsync low.
//    Both saturate at IMG_HDISP-1 / IMG_VDISP-1.
//  - Two line buffers of IMG_HDISP x DATA_W, addressed by col, written on clken: buf1 <= input, buf0 <= buf1 (read-before-write).
//  - Window: on clken, 3 column taps {buf0, buf1, input} shift into a 3x3 register array (W stage).
//  - Window rows = input lines r-2, r-1, r; columns c-2, c-1, c. Output (r,c) is the rank of the window centred on (r-1,c-1).
//  - Pipeline runs every clock (not clken-gated) and is fixed:
//    W (window reg) -> S1 (sort each row of 3) -> S2 (min/med/max of columns) -> S3 (final select); LAT = 4 clocks.
//  - Ranks: min = min of the 3 row mins; max = max of the 3 row maxes; median = med(max of mins, med of meds, min of maxes).
//  - Border: r<2 or c<2 -> border pixel. Output = 0 if border_mode=0, else input pixel (r,c) delayed LAT clocks.
//  - Pixels with col already at IMG_HDISP-1 (over-long line): not written to the line buffers; output treated as border.
//  - Bypass (mode 3): output = input pixel delayed LAT clocks for every pixel, border or not.
//  - Mode lock: rank_sel and border_mode are sampled on the vsync rising edge and held for the whole frame.
//    Mid-frame changes take effect at the next frame.
//  - Unsigned compares only; no arithmetic widening; output width = DATA_W.
//  - Sync outputs are pure LAT-clock delays of the inputs, independent of mode.
//    Back-to-back clken (every clock) is supported at full rate.
//  - Reset asserted mid-frame: outputs 0 immediately. Filtering resumes at the next vsync rising edge.
//    Pixels before that edge output as border.
// TESTING
//  - Ramp 10x8 frame (IMG_HDISP=10, IMG_VDISP=8), pixel = 10*r+c, median -> out(r,c) = 10*(r-1)+(c-1) for r,c>=2, latency 4 clk.
//  - Same ramp: min -> out(r,c) = 10*(r-2)+(c-2); max -> out(r,c) = 10*r+c; border_mode=0 -> rows 0-1 and cols 0-1 output 0.
//  - Flat 0x40 field with a single 0xFF impulse at (3,4), median -> every output 0x40; max -> 0xFF at outputs (3..5, 4..6).
//  - rank_sel 1->3 toggled mid-frame 1 -> frame 1 stays median throughout; frame 2 output = input delayed exactly 4 clocks.
//  - DATA_W=10, pixels 0x3FF/0x000 checkerboard, median -> 0x3FF where the window holds 5 ones, 0x000 otherwise; no truncation.
//  - rst_n pulsed low at row 4 -> outputs 0 during reset. Rest of that frame is border output.
//    Next frame matches the ramp check above; vsync/href/clken stay 4-clock aligned.

Source files
------------

// File: rtl/vip_gray_rank_filter.sv
// 3x3 rank-order filter (min / median / max / bypass) on a vsync/href/clken gray pixel stream.
// Mode is locked at each vsync rising edge; fixed 4-clock latency on data and sync outputs.
module vip_gray_rank_filter #(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_Gray,
  input  logic [1:0]        rank_sel,
  input  logic              border_mode,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Gray
);

  localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_HDISP - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_VDISP - 1);
  localparam logic [1:0] MODE_MIN = 2'd0;
  localparam logic [1:0] MODE_MED = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;
  localparam logic [1:0] MODE_BYP = 2'd3;

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // vsync_d resets high so a reset released mid-frame does not look like a frame start.
  logic          vsync_d, href_d, armed, line_full, bmode_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic vsync_rise, href_fall, over_long, wr_en, armed_cur, bmode_cur;
  logic [1:0] mode_cur;

  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = ~per_frame_href & href_d;
  assign over_long  = per_frame_clken & line_full;
  assign wr_en      = per_frame_clken & ~line_full;
  assign armed_cur  = armed | vsync_rise;
  assign mode_cur   = vsync_rise ? rank_sel : mode_q;
  assign bmode_cur  = vsync_rise ? border_mode : bmode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d   <= 1'b1;
      href_d    <= 1'b0;
      armed     <= 1'b0;
      line_full <= 1'b0;
      mode_q    <= MODE_MED;
      bmode_q   <= 1'b0;
      col       <= '0;
      row       <= '0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      if (vsync_rise) begin
        armed   <= 1'b1;
        mode_q  <= rank_sel;
        bmode_q <= border_mode;
      end
      if (href_fall) begin
        col       <= '0;
        line_full <= 1'b0;
      end else if (per_frame_clken) begin
        if (col == COL_LAST) line_full <= 1'b1;
        else                 col <= col + 1'b1;
      end
      if (!per_frame_vsync)                  row <= '0;
      else if (href_fall && row != ROW_LAST) row <= row + 1'b1;
    end
  end

  // Line buffers: buf0 holds line r-2, buf1 line r-1 at each column.
  pix_t buf0 [IMG_HDISP];
  pix_t buf1 [IMG_HDISP];
  pix_t tap0, tap1;

  assign tap0 = buf0[col];
  assign tap1 = buf1[col];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf1[col] <= per_img_Gray;
      buf0[col] <= tap1;
    end
  end

  // W stage: window plus per-pixel control flags travelling alongside.
  pix_t       win [3][3];
  logic       f0_border, f1_border, f2_border;
  logic       f0_bmode, f1_bmode, f2_bmode;
  logic [1:0] f0_mode, f1_mode, f2_mode;
  pix_t       f0_raw, f1_raw, f2_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
      f0_border <= 1'b0;
      f0_bmode  <= 1'b0;
      f0_mode   <= MODE_MED;
      f0_raw    <= '0;
    end else if (per_frame_clken) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= tap0;
      win[1][2] <= tap1;
      win[2][2] <= per_img_Gray;
      f0_border <= ~armed_cur | over_long | (row < RW'(2)) | (col < CW'(2));
      f0_bmode  <= bmode_cur;
      f0_mode   <= mode_cur;
      f0_raw    <= per_img_Gray;
    end
  end

  // S1 sorts each window row; S2 reduces across rows.
  pix_t lo [3];
  pix_t mid [3];
  pix_t hi [3];
  pix_t min_lo, max_lo, med_mid, min_hi, max_hi;
  pix_t s3_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        lo[i]  <= '0;
        mid[i] <= '0;
        hi[i]  <= '0;
      end
      min_lo <= '0; max_lo <= '0; med_mid <= '0; min_hi <= '0; max_hi <= '0;
      f1_border <= 1'b0; f1_bmode <= 1'b0; f1_mode <= MODE_MED; f1_raw <= '0;
      f2_border <= 1'b0; f2_bmode <= 1'b0; f2_mode <= MODE_MED; f2_raw <= '0;
      post_img_Gray <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        lo[i]  <= min2(min2(win[i][0], win[i][1]), win[i][2]);
        mid[i] <= med3(win[i][0], win[i][1], win[i][2]);
        hi[i]  <= max2(max2(win[i][0], win[i][1]), win[i][2]);
      end
      min_lo  <= min2(min2(lo[0], lo[1]), lo[2]);
      max_lo  <= max2(max2(lo[0], lo[1]), lo[2]);
      med_mid <= med3(mid[0], mid[1], mid[2]);
      min_hi  <= min2(min2(hi[0], hi[1]), hi[2]);
      max_hi  <= max2(max2(hi[0], hi[1]), hi[2]);
      f1_border <= f0_border; f1_bmode <= f0_bmode; f1_mode <= f0_mode; f1_raw <= f0_raw;
      f2_border <= f1_border; f2_bmode <= f1_bmode; f2_mode <= f1_mode; f2_raw <= f1_raw;
      post_img_Gray <= s3_next;
    end
  end

  always_comb begin
    s3_next = med3(max_lo, med_mid, min_hi);
    case (f2_mode)
      MODE_MIN: s3_next = min_lo;
      MODE_MAX: s3_next = max_hi;
      MODE_BYP: s3_next = f2_raw;
      default:  s3_next = med3(max_lo, med_mid, min_hi);
    endcase
    if (f2_mode != MODE_BYP && f2_border)
      s3_next = f2_bmode ? f2_raw : '0;
  end

  logic [3:0] vs_sr, hr_sr, ck_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr <= '0;
      hr_sr <= '0;
      ck_sr <= '0;
    end else begin
      vs_sr <= {vs_sr[2:0], per_frame_vsync};
      hr_sr <= {hr_sr[2:0], per_frame_href};
      ck_sr <= {ck_sr[2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vs_sr[3];
  assign post_frame_href  = hr_sr[3];
  assign post_frame_clken = ck_sr[3];

endmodule

// File: tb/tb_vip_gray_rank_filter.sv
// Directed bench for vip_gray_rank_filter on a 10x8 image with 10-bit pixels.
// Expected pixels come from closed-form results for ramp, impulse and checkerboard fields.
module tb_vip_gray_rank_filter;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         per_frame_vsync = 1'b0;
  logic         per_frame_href = 1'b0;
  logic         per_frame_clken = 1'b0;
  logic [W-1:0] per_img_Gray = '0;
  logic [1:0]   rank_sel = 2'd1;
  logic         border_mode = 1'b0;
  logic         post_frame_vsync, post_frame_href, post_frame_clken;
  logic [W-1:0] post_img_Gray;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0][2:0] hv = '0;

  vip_gray_rank_filter #(.DATA_W(W), .IMG_HDISP(10), .IMG_VDISP(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Gray     (per_img_Gray),
    .rank_sel         (rank_sel),
    .border_mode      (border_mode),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Gray    (post_img_Gray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0 = ramp, 1 = flat 0x40 with impulse at (3,4), 2 = 0x3FF/0 checkerboard
  function automatic logic [W-1:0] pix(input int kind, input int r, input int c);
    case (kind)
      0:       return W'(10 * r + c);
      1:       return (r == 3 && c == 4) ? W'('hFF) : W'('h40);
      default: return ((r + c) % 2 == 1) ? W'('h3FF) : W'(0);
    endcase
  endfunction

  function automatic logic [W-1:0] expv(input int kind, input logic [1:0] sel,
                                        input logic bm, input int r, input int c);
    if (sel == 2'd3) return pix(kind, r, c);
    if (r < 2 || c < 2) return bm ? pix(kind, r, c) : W'(0);
    case (kind)
      0: begin
        if (sel == 2'd0) return W'(10 * (r - 2) + (c - 2));
        if (sel == 2'd2) return W'(10 * r + c);
        return W'(10 * (r - 1) + (c - 1));
      end
      1: return (sel == 2'd2 && r >= 3 && r <= 5 && c >= 4 && c <= 6) ? W'('hFF) : W'('h40);
      default: begin
        if (sel == 2'd0) return W'(0);
        if (sel == 2'd2) return W'('h3FF);
        return ((r + c) % 2 == 1) ? W'('h3FF) : W'(0);
      end
    endcase
  endfunction

  // Monitor: sync outputs must equal inputs seen four cycles earlier; pixels drain exp_q.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_sync", {post_frame_vsync, post_frame_href, post_frame_clken}, 3'b000);
      check("rst_pix", post_img_Gray, 0);
      hv = '0;
    end else begin
      check("sync_align", {post_frame_vsync, post_frame_href, post_frame_clken}, hv[3]);
      hv = {hv[2:0], {per_frame_vsync, per_frame_href, per_frame_clken}};
      if (post_frame_clken) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL pix_extra: observed %0h expected no pixel", post_img_Gray);
        end else begin
          check("pix", post_img_Gray, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_frame(input int kind, input logic [1:0] sel, input logic bm,
                             input int tog_row, input logic [1:0] tog_sel, input int rst_row);
    bit dead;
    dead = 1'b0;
    rank_sel = sel;
    border_mode = bm;
    per_frame_vsync = 1'b0;
    repeat (3) tick();
    per_frame_vsync = 1'b1;
    repeat (2) tick();
    for (int r = 0; r < 8; r++) begin
      if (r == tog_row) rank_sel = tog_sel;
      if (r == rst_row) begin
        rst_n = 1'b0;
        #1;
        check("rst_now_vsync", post_frame_vsync, 0);
        check("rst_now_pix", post_img_Gray, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        dead = 1'b1;
      end
      per_frame_href = 1'b1;
      for (int c = 0; c < 10; c++) begin
        per_frame_clken = 1'b1;
        per_img_Gray = pix(kind, r, c);
        exp_q.push_back(dead ? W'(0) : expv(kind, sel, bm, r, c));
        tick();
      end
      per_frame_clken = 1'b0;
      per_frame_href = 1'b0;
      repeat (6) tick();
    end
    per_frame_vsync = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    drive_frame(0, 2'd1, 1'b1, -1, 2'd0, -1);  // ramp median, raw border
    drive_frame(0, 2'd0, 1'b0, -1, 2'd0, -1);  // ramp min
    drive_frame(0, 2'd2, 1'b0, -1, 2'd0, -1);  // ramp max
    drive_frame(1, 2'd1, 1'b0, -1, 2'd0, -1);  // impulse median
    drive_frame(1, 2'd2, 1'b1, -1, 2'd0, -1);  // impulse max
    drive_frame(2, 2'd1, 1'b0, -1, 2'd0, -1);  // checkerboard median
    drive_frame(2, 2'd2, 1'b0, -1, 2'd0, -1);  // checkerboard max
    drive_frame(0, 2'd1, 1'b1, 3, 2'd3, -1);   // mid-frame switch to bypass stays median
    drive_frame(0, 2'd3, 1'b0, -1, 2'd0, -1);  // bypass frame
    drive_frame(0, 2'd1, 1'b1, -1, 2'd0, 4);   // reset at row 4
    drive_frame(0, 2'd1, 1'b0, -1, 2'd0, -1);  // recovery frame
    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
